// File: rtl/maze_input_pkg.sv
// ---------------------------------------------------------------------------------------------
// maze_input_pkg
//   Shared definitions for the maze button input stage.
//   - btn_state_e : per-button conditioner FSM states (3-bit encoding, IDLE..DEB_REL)
//   - DEF_*       : default timing constants for a 100 MHz clock
//   - BTN_*       : bit positions of each direction in the button buses
//   - cnt_width() : width of the shared per-button dwell counter
// ---------------------------------------------------------------------------------------------
package maze_input_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DEB_PRE = 3'd1,
        SCEN    = 3'd2,
        HOLD    = 3'd3,
        MCEN    = 3'd4,
        REPEAT  = 3'd5,
        DEB_REL = 3'd6
    } btn_state_e;

    // 25 ms debounce, 0.5 s before auto-repeat, 125 ms repeat spacing @ 100 MHz
    localparam int unsigned DEF_N_BTN         = 4;
    localparam int unsigned DEF_DEB_CYCLES    = 2_500_000;
    localparam int unsigned DEF_HOLD_CYCLES   = 50_000_000;
    localparam int unsigned DEF_REPEAT_CYCLES = 12_500_000;

    localparam int unsigned BTN_UP    = 0;
    localparam int unsigned BTN_DOWN  = 1;
    localparam int unsigned BTN_LEFT  = 2;
    localparam int unsigned BTN_RIGHT = 3;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // One counter serves every timed state, so it must hold the largest limit.
    function automatic int unsigned cnt_width(input int unsigned deb, input int unsigned hold,
                                              input int unsigned rpt);
        return $clog2(max3(deb, hold, rpt) + 1);
    endfunction

endpackage

// File: rtl/debounce_fsm.sv
// ---------------------------------------------------------------------------------------------
// debounce_fsm
//   Conditions one raw button: optional 2-flop synchronizer, dwell counter and the
//   IDLE/DEB_PRE/SCEN/HOLD/MCEN/REPEAT/DEB_REL state machine. Outputs are registered
//   decodes of the next state, so they line up with the state register.
//
//   Configuration macro: BTN_SYNC2_EN
//     defined   : btn_i passes through a 2-flop synchronizer (adds 2 cycles of latency)
//     undefined : btn_i drives the FSM directly (input must already be synchronous)
//
//   Ports
//     clk    in   system clock
//     Reset  in   asynchronous, active-high reset
//     btn_i  in   raw active-high button
//     dpb_o  out  debounced level
//     scen_o out  single-cycle pulse per accepted press
//     mcen_o out  press pulse followed by auto-repeat pulses
//     ccen_o out  high during the press pulse and the whole repeat phase
// ---------------------------------------------------------------------------------------------
module debounce_fsm
    import maze_input_pkg::*;
#(
    parameter int unsigned DEB_CYCLES    = DEF_DEB_CYCLES,
    parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic Reset,
    input  logic btn_i,
    output logic dpb_o,
    output logic scen_o,
    output logic mcen_o,
    output logic ccen_o
);

    localparam int unsigned CntW = cnt_width(DEB_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);

    // A state with limit L is left on the edge where cnt already equals L-1, giving L cycles
    // of dwell (cnt is cleared on entry).
    localparam logic [CntW-1:0] DebLast  = CntW'(DEB_CYCLES - 1);
    localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CYCLES - 1);
    localparam logic [CntW-1:0] RepLast  = CntW'(REPEAT_CYCLES - 1);
    localparam logic [CntW-1:0] CntMax   = {CntW{1'b1}};

    logic btn_s;

`ifdef BTN_SYNC2_EN
    logic [1:0] sync_q, sync_d;

    assign sync_d = {sync_q[0], btn_i};
    assign btn_s  = sync_q[1];

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= sync_d;
        end
    end
`else
    assign btn_s = btn_i;
`endif

    btn_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
    logic            dpb_q, dpb_d;
    logic            scen_q, scen_d;
    logic            mcen_q, mcen_d;
    logic            ccen_q, ccen_d;

    // Saturate so a long dwell in IDLE can never wrap back into a false match.
    assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_inc;
        unique case (state_q)
            IDLE: begin
                if (btn_s) state_d = DEB_PRE;
            end
            DEB_PRE: begin
                if (!btn_s) begin
                    state_d = IDLE;
                end else if (cnt_q == DebLast) begin
                    state_d = SCEN;
                end
            end
            SCEN: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (!btn_s) begin
                    state_d = DEB_REL;
                end else if (cnt_q == HoldLast) begin
                    state_d = MCEN;
                end
            end
            MCEN: begin
                state_d = REPEAT;
            end
            REPEAT: begin
                if (!btn_s) begin
                    state_d = DEB_REL;
                end else if (cnt_q == RepLast) begin
                    state_d = MCEN;
                end
            end
            DEB_REL: begin
                if (btn_s) begin
                    cnt_d = '0;
                end else if (cnt_q == DebLast) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    // Outputs decoded from the next state and registered alongside it.
    always_comb begin
        dpb_d  = 1'b0;
        scen_d = 1'b0;
        mcen_d = 1'b0;
        ccen_d = 1'b0;
        unique case (state_d)
            SCEN: begin
                dpb_d  = 1'b1;
                scen_d = 1'b1;
                mcen_d = 1'b1;
                ccen_d = 1'b1;
            end
            HOLD, DEB_REL: begin
                dpb_d = 1'b1;
            end
            MCEN: begin
                dpb_d  = 1'b1;
                mcen_d = 1'b1;
                ccen_d = 1'b1;
            end
            REPEAT: begin
                dpb_d  = 1'b1;
                ccen_d = 1'b1;
            end
            default: begin
                dpb_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dpb_q   <= 1'b0;
            scen_q  <= 1'b0;
            mcen_q  <= 1'b0;
            ccen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dpb_q   <= dpb_d;
            scen_q  <= scen_d;
            mcen_q  <= mcen_d;
            ccen_q  <= ccen_d;
        end
    end

    assign dpb_o  = dpb_q;
    assign scen_o = scen_q;
    assign mcen_o = mcen_q;
    assign ccen_o = ccen_q;

endmodule

// File: rtl/maze_button_conditioner.sv
// ---------------------------------------------------------------------------------------------
// maze_button_conditioner
//   Input stage ahead of Game_Logic: one independent debounce_fsm per direction button.
//   Bus bit map: [0]=up, [1]=down, [2]=left, [3]=right (see BTN_* in maze_input_pkg).
//
//   Configuration macro: BTN_SYNC2_EN (2-flop input synchronizer inside each debounce_fsm)
//
//   Ports
//     clk      in   system clock
//     Reset    in   asynchronous, active-high reset
//     btn_raw  in   [N_BTN] raw active-high buttons
//     DPBs     out  [N_BTN] debounced levels
//     SCENs    out  [N_BTN] single-cycle press pulses
//     MCENs    out  [N_BTN] press pulse then auto-repeat pulses while held
//     CCENs    out  [N_BTN] continuous enable during press pulse and repeat phase
//
//   All timing parameters must be >= 1.
// ---------------------------------------------------------------------------------------------
module maze_button_conditioner
    import maze_input_pkg::*;
#(
    parameter int unsigned N_BTN         = DEF_N_BTN,
    parameter int unsigned DEB_CYCLES    = DEF_DEB_CYCLES,
    parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] DPBs,
    output logic [N_BTN-1:0] SCENs,
    output logic [N_BTN-1:0] MCENs,
    output logic [N_BTN-1:0] CCENs
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        debounce_fsm #(
            .DEB_CYCLES   (DEB_CYCLES),
            .HOLD_CYCLES  (HOLD_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES)
        ) u_debounce_fsm (
            .clk   (clk),
            .Reset (Reset),
            .btn_i (btn_raw[i]),
            .dpb_o (DPBs[i]),
            .scen_o(SCENs[i]),
            .mcen_o(MCENs[i]),
            .ccen_o(CCENs[i])
        );
    end

endmodule

// File: tb/tb_maze_button_conditioner.sv
// ---------------------------------------------------------------------------------------------
// tb_maze_button_conditioner
//   Scoreboard bench: a reference model computes each cycle's expected outputs from the
//   debounce/hold/repeat timing rules and queues them; a monitor pops and compares.
//   Directed scenarios (glitch, tap, hold, bounce, simultaneous, reset mid-hold) add
//   absolute edge-count checks; a randomized phase follows.
// ---------------------------------------------------------------------------------------------
module tb_maze_button_conditioner;

    localparam int Deb  = 4;
    localparam int Hold = 8;
    localparam int Rep  = 3;
`ifdef BTN_SYNC2_EN
    localparam int SyncLat = 2;
`else
    localparam int SyncLat = 0;
`endif

    logic       clk = 1'b0;
    logic       Reset = 1'b1;
    logic [3:0] btn_raw = 4'b0000;
    logic [3:0] dpbs, scens, mcens, ccens;

    always #5 clk = ~clk;

    maze_button_conditioner #(
        .N_BTN        (4),
        .DEB_CYCLES   (Deb),
        .HOLD_CYCLES  (Hold),
        .REPEAT_CYCLES(Rep)
    ) dut (
        .clk    (clk),
        .Reset  (Reset),
        .btn_raw(btn_raw),
        .DPBs   (dpbs),
        .SCENs  (scens),
        .MCENs  (mcens),
        .CCENs  (ccens)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] exp_q[$];

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    // Per button: mode 0 = released, 1 = held (age = edges since the press pulse),
    // 2 = releasing. Pulse positions follow from age arithmetic.
    int         mode[4];
    int         run[4];
    int         age[4];
    int         relz[4];
    logic [3:0] p1 = 4'b0000;
    logic [3:0] p2 = 4'b0000;

    function automatic bit is_pulse(input int a);
        return (a == 0) || (a >= Hold + 1 && ((a - Hold - 1) % (Rep + 1)) == 0);
    endfunction

    initial begin
        logic [3:0]  s;
        logic [15:0] e;
        for (int i = 0; i < 4; i++) begin
            mode[i] = 0; run[i] = 0; age[i] = 0; relz[i] = 0;
        end
        forever begin
            @(posedge clk);
            e = '0;
            if (Reset) begin
                p1 = '0;
                p2 = '0;
                for (int i = 0; i < 4; i++) begin
                    mode[i] = 0; run[i] = 0; age[i] = 0; relz[i] = 0;
                end
            end else begin
`ifdef BTN_SYNC2_EN
                s  = p2;
                p2 = p1;
                p1 = btn_raw;
`else
                s = btn_raw;
`endif
                for (int i = 0; i < 4; i++) begin
                    case (mode[i])
                        0: begin
                            if (s[i]) begin
                                run[i]++;
                                // entry sample plus Deb stable samples
                                if (run[i] == Deb + 1) begin
                                    mode[i] = 1; age[i] = 0; run[i] = 0;
                                end
                            end else begin
                                run[i] = 0;
                            end
                        end
                        1: begin
                            if (!is_pulse(age[i]) && !s[i]) begin
                                mode[i] = 2; relz[i] = 0;
                            end else begin
                                age[i]++;
                            end
                        end
                        default: begin
                            if (s[i]) begin
                                relz[i] = 0;
                            end else begin
                                relz[i]++;
                                if (relz[i] == Deb) mode[i] = 0;
                            end
                        end
                    endcase
                    if (mode[i] != 0) e[i] = 1'b1;
                    if (mode[i] == 1) begin
                        e[4 + i]  = (age[i] == 0);
                        e[8 + i]  = is_pulse(age[i]);
                        e[12 + i] = (age[i] == 0) || (age[i] >= Hold + 1);
                    end
                end
            end
            exp_q.push_back(e);
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic [15:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL scoreboard: got no expectation, expected one queued (t=%0t)", $time);
            end else begin
                e = exp_q.pop_front();
                check("outputs{CC,MC,SC,DPB}", 32'({ccens, mcens, scens, dpbs}), 32'(e));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic [3:0] b, input logic r);
        @(negedge clk);
        btn_raw = b;
        Reset   = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          first_scen, scen_cnt, last_dpb, min_dpb, any_out;
        int          mcen_edges[$];
        logic [3:0]  first_val, cur;

        // reset
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        check("reset_outputs", 32'({ccens, mcens, scens, dpbs}), 32'h0);
        step(4'b0000, 1'b0);
        check("first_cycle_after_reset", 32'({ccens, mcens, scens, dpbs}), 32'h0);
        repeat (4) step(4'b0000, 1'b0);

        // 1 glitch on up: 3 high cycles are rejected
        any_out = 0;
        for (int e = 1; e <= 15; e++) begin
            step((e <= 3) ? 4'b0001 : 4'b0000, 1'b0);
            if ({ccens[0], mcens[0], scens[0], dpbs[0]} != 4'b0000) any_out = 1;
        end
        check("glitch_no_output", 32'(any_out), 32'd0);

        // 2 tap on left
        first_scen = -1; scen_cnt = 0; last_dpb = -1;
        mcen_edges.delete();
        for (int e = 1; e <= 30; e++) begin
            step((e <= 10) ? 4'b0100 : 4'b0000, 1'b0);
            if (scens[2]) begin
                scen_cnt++;
                if (first_scen < 0) first_scen = e;
            end
            if (mcens[2]) mcen_edges.push_back(e);
            if (dpbs[2]) last_dpb = e;
        end
        check("tap_scen_edge", 32'(first_scen), 32'(SyncLat + 5));
        check("tap_scen_count", 32'(scen_cnt), 32'd1);
        check("tap_mcen_count", 32'(mcen_edges.size()), 32'd1);
        check("tap_dpb_fall_edge", 32'(last_dpb + 1), 32'(11 + SyncLat + 4));

        // 3 hold on right for 40 cycles
        scen_cnt = 0;
        mcen_edges.delete();
        for (int e = 1; e <= 60; e++) begin
            step((e <= 40) ? 4'b1000 : 4'b0000, 1'b0);
            if (scens[3]) scen_cnt++;
            if (mcens[3]) mcen_edges.push_back(e);
        end
        check("hold_scen_count", 32'(scen_cnt), 32'd1);
        check("hold_mcen_count", 32'(mcen_edges.size()), 32'd8);
        if (mcen_edges.size() >= 3) begin
            check("hold_mcen0_edge", 32'(mcen_edges[0]), 32'(SyncLat + 5));
            check("hold_mcen1_edge", 32'(mcen_edges[1]), 32'(SyncLat + 14));
            check("hold_mcen2_edge", 32'(mcen_edges[2]), 32'(SyncLat + 18));
        end

        // 4 bounce on release of down
        scen_cnt = 0; min_dpb = 1;
        for (int e = 1; e <= 20; e++) begin
            step(4'b0010, 1'b0);
            if (scens[1]) scen_cnt++;
        end
        for (int e = 0; e < 12; e++) begin
            step(((e % 3) == 0) ? 4'b0000 : 4'b0010, 1'b0);
            if (scens[1]) scen_cnt++;
            if (!dpbs[1]) min_dpb = 0;
        end
        check("bounce_dpb_held", 32'(min_dpb), 32'd1);
        for (int e = 1; e <= 15; e++) begin
            step(4'b0000, 1'b0);
            if (scens[1]) scen_cnt++;
        end
        check("bounce_scen_count", 32'(scen_cnt), 32'd1);
        check("bounce_dpb_released", 32'(dpbs[1]), 32'd0);

        // 5 simultaneous up+down
        first_scen = -1; first_val = 4'b0000;
        for (int e = 1; e <= 30; e++) begin
            step((e <= 12) ? 4'b0011 : 4'b0000, 1'b0);
            if (scens != 4'b0000 && first_scen < 0) begin
                first_scen = e;
                first_val  = scens;
            end
        end
        check("simul_scen_edge", 32'(first_scen), 32'(SyncLat + 5));
        check("simul_scen_value", 32'(first_val), 32'h3);

        // 6 reset while right is in the repeat phase
        for (int e = 1; e <= 22; e++) step(4'b1000, 1'b0);
        check("prereset_dpb", 32'(dpbs[3]), 32'd1);
        @(negedge clk);
        Reset = 1'b1;
        #1;
        check("reset_immediate", 32'({ccens, mcens, scens, dpbs}), 32'h0);
        step(4'b1000, 1'b1);
        step(4'b1000, 1'b1);
        first_scen = -1;
        for (int e = 1; e <= 14; e++) begin
            step(4'b1000, 1'b0);
            if (scens[3] && first_scen < 0) first_scen = e;
        end
        check("postreset_scen_edge", 32'(first_scen), 32'(SyncLat + 5));
        for (int e = 1; e <= 20; e++) step(4'b0000, 1'b0);

        // randomized: independent toggling per button, occasional reset
        cur = 4'b0000;
        for (int e = 0; e < 900; e++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 5) == 0) cur[i] = ~cur[i];
            end
            step(cur, ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
        end
        for (int e = 1; e <= 20; e++) step(4'b0000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
